interp_block_sequencer: RTL and testbench

//  Sequences one 8x8 sub-pixel interpolation block through the datapath.

---
 rtl/interp_block_sequencer.sv | 109 ++++++++++
 tb/tb_interp_block_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/interp_block_sequencer.sv
// interp_block_sequencer: loads one reference block into the shift register, steers filtered rows
// into the output filler, and hands the finished block downstream.
module interp_block_sequencer #(
  parameter int ROWS_IN  = 15,
  parameter int ROWS_OUT = 8,
  parameter int TIMEOUT  = 64,
  parameter int SEL_W    = 8
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shreg_load_L,
  output logic             filt_start,
  input  logic             filt_valid,
  output logic             ofill_load_L,
  output logic [SEL_W-1:0] ofill_sel,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             busy,
  output logic [1:0]       err,
  output logic [15:0]      blk_cnt
);
  localparam int RW = $clog2(ROWS_IN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS_IN - 1);
  localparam logic [SEL_W-1:0] OUT_LAST = SEL_W'(ROWS_OUT - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t state, state_nx;
  logic [RW-1:0] row_cnt, row_nx;
  logic [SEL_W-1:0] out_cnt, out_nx;
  logic [WW-1:0] wd_cnt, wd_nx;
  logic start_nx;
  logic [1:0] err_nx;
  logic [15:0] cnt_nx;
  logic xfer;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state      <= IDLE;
      row_cnt    <= '0;
      out_cnt    <= '0;
      wd_cnt     <= '0;
      filt_start <= 1'b0;
      err        <= 2'b00;
      blk_cnt    <= '0;
    end else begin
      state      <= state_nx;
      row_cnt    <= row_nx;
      out_cnt    <= out_nx;
      wd_cnt     <= wd_nx;
      filt_start <= start_nx;
      err        <= err_nx;
      blk_cnt    <= cnt_nx;
    end
  end

  assign xfer = in_valid & in_ready;

  always_comb begin
    state_nx = state;
    row_nx   = row_cnt;
    out_nx   = out_cnt;
    wd_nx    = wd_cnt;
    start_nx = 1'b0;
    err_nx   = {err[1] | (filt_valid & (state != RUN)), err[0]};
    cnt_nx   = blk_cnt;
    case (state)
      IDLE: if (xfer) begin
        state_nx = FILL;
        row_nx   = RW'(1);
      end
      FILL: if (xfer) begin
        state_nx = (row_cnt == ROW_LAST) ? RUN : FILL;
        row_nx   = (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
        start_nx = (row_cnt == ROW_LAST);
        wd_nx    = '0;
      end
      RUN: if (filt_valid) begin
        state_nx = (out_cnt == OUT_LAST) ? DONE : RUN;
        out_nx   = (out_cnt == OUT_LAST) ? '0 : out_cnt + SEL_W'(1);
        wd_nx    = '0;
      end else if (wd_cnt == WD_LAST) begin
        state_nx  = IDLE;
        out_nx    = '0;
        err_nx[0] = 1'b1;
      end else begin
        wd_nx = wd_cnt + WW'(1);
      end
      DONE: if (blk_ready) begin
        state_nx = IDLE;
        cnt_nx   = blk_cnt + 16'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state == IDLE) || (state == FILL);
    shreg_load_L = ~(in_valid & in_ready);
    ofill_load_L = ~(filt_valid & (state == RUN));
    ofill_sel    = out_cnt;
    blk_valid    = (state == DONE);
    busy         = (state != IDLE);
  end
endmodule

// File: tb/tb_interp_block_sequencer.sv
// tb_interp_block_sequencer: directed vectors with hand-computed expectations for the block sequencer.
module tb_interp_block_sequencer;
  logic clock = 1'b0;
  logic reset_L = 1'b0;
  logic in_valid = 1'b0, filt_valid = 1'b0, blk_ready = 1'b0;
  logic in_ready, shreg_load_L, filt_start, ofill_load_L, blk_valid, busy;
  logic [7:0] ofill_sel;
  logic [1:0] err;
  logic [15:0] blk_cnt;
  int total = 0, bad = 0;
  int gaps [8] = '{0, 1, 2, 3, 4, 5, 0, 1};

  interp_block_sequencer dut (
    .clock(clock), .reset_L(reset_L), .in_valid(in_valid), .in_ready(in_ready),
    .shreg_load_L(shreg_load_L), .filt_start(filt_start), .filt_valid(filt_valid),
    .ofill_load_L(ofill_load_L), .ofill_sel(ofill_sel), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .busy(busy), .err(err), .blk_cnt(blk_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_shreg", shreg_load_L, 1);
    check("rst_ofill", ofill_load_L, 1);
    check("rst_sel", ofill_sel, 0);
    check("rst_start", filt_start, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    reset_L = 1'b1;
    tick;
    // back-to-back fill
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      @(negedge clock);
      check("b2b_load", shreg_load_L, 0);
      check("b2b_start_low", filt_start, 0);
      tick;
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("b2b_start", filt_start, 1);
    check("b2b_busy", busy, 1);
    check("run_in_ready", in_ready, 0);
    tick;
    // filtered rows with gaps
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        filt_valid = 1'b0;
        @(negedge clock);
        check("gap_ofill_idle", ofill_load_L, 1);
        tick;
      end
      filt_valid = 1'b1;
      @(negedge clock);
      check("ofill_load", ofill_load_L, 0);
      check("ofill_sel", ofill_sel, k);
      check("run_start_low", filt_start, 0);
      check("run_blk_valid", blk_valid, 0);
      tick;
    end
    filt_valid = 1'b0;
    @(negedge clock);
    check("done_blk_valid", blk_valid, 1);
    tick;
    // downstream stall
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("stall_blk_valid", blk_valid, 1);
      check("stall_in_ready", in_ready, 0);
      tick;
    end
    blk_ready = 1'b1;
    @(negedge clock);
    check("hs_in_ready", in_ready, 0);
    check("hs_shreg", shreg_load_L, 1);
    tick;
    blk_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("hs_blk_cnt", blk_cnt, 1);
    check("hs_busy", busy, 0);
    check("hs_blk_valid", blk_valid, 0);
    check("idle_in_ready", in_ready, 1);
    tick;
    // gapped fill
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      @(negedge clock);
      check("gap_load", shreg_load_L, 0);
      check("gap_start_low", filt_start, 0);
      tick;
      in_valid = 1'b0;
      for (int j = 0; j < 2; j++) begin
        @(negedge clock);
        check("gap_start", filt_start, (i == 14 && j == 0) ? 1 : 0);
        check("gap_busy", busy, 1);
        tick;
      end
    end
    // watchdog: RUN already spent two cycles
    for (int i = 0; i < 62; i++) begin
      @(negedge clock);
      check("wd_busy", busy, 1);
      check("wd_err", err, 0);
      check("wd_blk_valid", blk_valid, 0);
      tick;
    end
    @(negedge clock);
    check("wd_abort_busy", busy, 0);
    check("wd_abort_err", err, 1);
    check("wd_abort_blk_valid", blk_valid, 0);
    tick;
    // stray filter row in IDLE
    filt_valid = 1'b1;
    @(negedge clock);
    check("stray_ofill", ofill_load_L, 1);
    tick;
    filt_valid = 1'b0;
    @(negedge clock);
    check("stray_err", err, 3);
    tick;
    // reset in the middle of a fill
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick;
    in_valid = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_blk_cnt", blk_cnt, 0);
    @(negedge clock);
    reset_L = 1'b1;
    tick;
    in_valid = 1'b1;
    for (int i = 0; i < 14; i++) tick;
    in_valid = 1'b0;
    @(negedge clock);
    check("refill_14_start", filt_start, 0);
    check("refill_14_ready", in_ready, 1);
    tick;
    in_valid = 1'b1;
    @(negedge clock);
    check("refill_15_load", shreg_load_L, 0);
    tick;
    in_valid = 1'b0;
    @(negedge clock);
    check("refill_start", filt_start, 1);
    tick;
    filt_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("fast_sel", ofill_sel, k);
      tick;
    end
    filt_valid = 1'b0;
    blk_ready = 1'b1;
    @(negedge clock);
    check("fast_blk_valid", blk_valid, 1);
    tick;
    blk_ready = 1'b0;
    @(negedge clock);
    check("fast_blk_cnt", blk_cnt, 1);
    check("fast_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
